// File: rtl/aes_block_scroller.sv
// Holds one 128-bit AES result and shows it a byte at a time, advancing on a
// button edge or a prescaled tick, and flags equality with a reference block.
module aes_block_scroller #(
    parameter int unsigned DIV   = 50000000,
    parameter int unsigned LOOPS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    output logic         blk_ready,
    input  logic [127:0] ref_data,
    input  logic         step,
    input  logic         auto_en,
    input  logic         clear,
    output logic [7:0]   byte_out,
    output logic [3:0]   byte_idx,
    output logic         showing,
    output logic         match,
    output logic [3:0]   pass_cnt
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [127:0]    cap_q;
    logic            match_q;
    logic [3:0]      idx_q;
    logic [PW-1:0]   presc_q;
    logic            step_d;
    logic [3:0]      pass_q;
    logic [7:0]      hold_q;

    logic [7:0]      cur_byte;
    logic            in_show;
    logic            adv_step;
    logic            adv_tick;
    logic            adv;
    logic            wrap;
    logic [3:0]      pass_inc;
    logic            last_pass;
    logic            capture;

    // Advance, wrap and capture decode shared by the FSM and datapath
    always_comb begin
        cur_byte  = cap_q[{idx_q, 3'b000} +: 8];
        in_show   = (state == SHOW);
        adv_step  = in_show & step & ~step_d;
        adv_tick  = in_show & auto_en & (presc_q == PW'(DIV - 1));
        adv       = adv_step | adv_tick;
        wrap      = adv & (idx_q == 4'd15);
        pass_inc  = (pass_q == 4'd15) ? 4'd15 : pass_q + 4'd1;
        last_pass = wrap && (LOOPS != 0) && (32'(pass_inc) == LOOPS);
        capture   = (state == IDLE) & blk_valid & ~clear;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear always returns to IDLE
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (blk_valid) state_nxt = SHOW;
                SHOW: if (last_pass) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // In IDLE the display keeps the last byte shown before leaving SHOW
    always_comb begin
        blk_ready = (state == IDLE);
        showing   = (state == SHOW);
        byte_out  = (state == SHOW) ? cur_byte : hold_q;
        byte_idx  = idx_q;
        match     = match_q;
        pass_cnt  = pass_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q   <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
            presc_q <= '0;
            step_d  <= 1'b0;
            pass_q  <= '0;
            hold_q  <= '0;
        end else begin
            step_d <= step;
            if (clear) begin
                idx_q   <= '0;
                presc_q <= '0;
                if (in_show) hold_q <= cur_byte;
            end else if (capture) begin
                cap_q   <= blk_data;
                match_q <= (blk_data == ref_data);
                idx_q   <= '0;
                presc_q <= '0;
                pass_q  <= '0;
            end else if (in_show) begin
                if (auto_en) begin
                    presc_q <= adv_tick ? '0 : presc_q + PW'(1);
                end
                if (adv) idx_q <= idx_q + 4'd1;
                if (wrap) pass_q <= pass_inc;
                if (last_pass) hold_q <= cur_byte;
            end
        end
    end

endmodule
